// File: rtl/ysyx_24100005_mem_arbiter.sv
// Round-robin arbiter between IFU and LSU for the single data-memory port.
// One transaction at a time: IDLE (grant) -> REQ (memory handshake) -> RESP (response or timeout).
module ysyx_24100005_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    input  logic        if_wen,
    input  logic [31:0] if_wdata,
    input  logic [7:0]  if_wmask,
    output logic        if_resp_valid,
    output logic [31:0] if_rdata,
    output logic        if_resp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_addr,
    input  logic        ls_wen,
    input  logic [31:0] ls_wdata,
    input  logic [7:0]  ls_wmask,
    output logic        ls_resp_valid,
    output logic [31:0] ls_rdata,
    output logic        ls_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;
    logic        r_last;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [15:0] r_cnt;

    logic        w_grant;
    logic        w_grant_ls;
    logic        w_timeout;
    logic        w_resp_fire;
    logic [31:0] w_rdata;
    logic        w_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant decision and next state; a tie goes to whoever was not granted last.
    always_comb begin
        w_grant      = 1'b0;
        w_grant_ls   = 1'b0;
        w_state_next = r_state;
        w_timeout    = (r_cnt == LP_CNT_LAST);
        w_resp_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    if (if_req_valid && ls_req_valid) begin
                        w_grant    = 1'b1;
                        w_grant_ls = ~r_last;
                    end else if (if_req_valid) begin
                        w_grant    = 1'b1;
                    end else if (ls_req_valid) begin
                        w_grant    = 1'b1;
                        w_grant_ls = 1'b1;
                    end
                end
                if (w_grant) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_fire = ~rst & (mem_resp_valid | w_timeout);
                if (mem_resp_valid || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= 32'd0;
            r_wen   <= 1'b0;
            r_wdata <= 32'd0;
            r_wmask <= 8'd0;
            r_cnt   <= 16'd0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_ls;
                r_last  <= w_grant_ls;
                r_addr  <= w_grant_ls ? ls_addr  : if_addr;
                r_wen   <= w_grant_ls ? ls_wen   : if_wen;
                r_wdata <= w_grant_ls ? ls_wdata : if_wdata;
                r_wmask <= w_grant_ls ? ls_wmask : if_wmask;
            end
            if (r_state == ST_REQ && mem_req_ready) begin
                r_cnt <= 16'd0;
            end else if (r_state == ST_RESP && !mem_resp_valid && !w_timeout) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // A real response beats a timeout landing in the same cycle.
    assign w_rdata = mem_resp_valid ? mem_rdata : 32'd0;
    assign w_err   = ~mem_resp_valid;

    assign if_req_ready  = w_grant & ~w_grant_ls;
    assign ls_req_ready  = w_grant & w_grant_ls;

    assign mem_req_valid = (r_state == ST_REQ) & ~rst;
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    assign if_resp_valid = w_resp_fire & ~r_owner;
    assign if_resp_err   = w_resp_fire & ~r_owner & w_err;
    assign if_rdata      = (w_resp_fire & ~r_owner) ? w_rdata : 32'd0;
    assign ls_resp_valid = w_resp_fire & r_owner;
    assign ls_resp_err   = w_resp_fire & r_owner & w_err;
    assign ls_rdata      = (w_resp_fire & r_owner) ? w_rdata : 32'd0;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter, built with TIMEOUT = 4.
module tb_ysyx_24100005_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_wen, if_resp_valid, if_resp_err;
    logic [31:0] if_addr, if_wdata, if_rdata;
    logic [7:0]  if_wmask;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ysyx_24100005_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_wen(if_wen), .if_wdata(if_wdata), .if_wmask(if_wmask),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_req_valid = 0; if_addr = 0; if_wen = 0; if_wdata = 0; if_wmask = 0;
        ls_req_valid = 0; ls_addr = 0; ls_wen = 0; ls_wdata = 0; ls_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        nxt();
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        smp();
        chk("reset_if_ready", {31'd0, if_req_ready}, 32'd0);
        chk("reset_ls_ready", {31'd0, ls_req_ready}, 32'd0);
        chk("reset_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        if_req_valid = 0;
        ls_req_valid = 0;
        do_reset();

        // Single IFU read
        if_req_valid = 1; if_addr = 32'h8000_0000; if_wen = 0;
        smp();
        chk("rd_if_ready_c0", {31'd0, if_req_ready}, 32'd1);
        chk("rd_mem_valid_c0", {31'd0, mem_req_valid}, 32'd0);
        nxt();
        if_req_valid = 0; mem_req_ready = 1;
        smp();
        chk("rd_mem_valid_c1", {31'd0, mem_req_valid}, 32'd1);
        chk("rd_mem_addr_c1", mem_addr, 32'h8000_0000);
        chk("rd_mem_wen_c1", {31'd0, mem_wen}, 32'd0);
        chk("rd_if_resp_c1", {31'd0, if_resp_valid}, 32'd0);
        nxt();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        smp();
        chk("rd_if_resp_c2", {31'd0, if_resp_valid}, 32'd1);
        chk("rd_if_rdata_c2", if_rdata, 32'h0000_0413);
        chk("rd_if_err_c2", {31'd0, if_resp_err}, 32'd0);
        chk("rd_ls_resp_c2", {31'd0, ls_resp_valid}, 32'd0);
        chk("rd_ls_rdata_c2", ls_rdata, 32'd0);
        nxt();
        mem_resp_valid = 0;

        // Contention from reset: IFU, LSU, IFU, LSU
        if_req_valid = 1; ls_req_valid = 1;
        ls_addr = 32'h8000_0100; ls_wen = 1; ls_wdata = 32'hDEAD_BEEF; ls_wmask = 8'h0F;
        mem_req_ready = 1; mem_resp_valid = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic is_ls;
            is_ls = (i % 2) == 1;
            mem_rdata = 32'h1000 + i;
            smp();
            chk($sformatf("cont%0d_if_ready", i), {31'd0, if_req_ready}, {31'd0, ~is_ls});
            chk($sformatf("cont%0d_ls_ready", i), {31'd0, ls_req_ready}, {31'd0, is_ls});
            nxt();
            smp();
            chk($sformatf("cont%0d_mem_valid", i), {31'd0, mem_req_valid}, 32'd1);
            chk($sformatf("cont%0d_mem_wen", i), {31'd0, mem_wen}, {31'd0, is_ls});
            chk($sformatf("cont%0d_if_resp_req", i), {31'd0, if_resp_valid}, 32'd0);
            if (is_ls) begin
                chk($sformatf("cont%0d_mem_wdata", i), mem_wdata, 32'hDEAD_BEEF);
                chk($sformatf("cont%0d_mem_wmask", i), {24'd0, mem_wmask}, 32'h0F);
                chk($sformatf("cont%0d_mem_addr", i), mem_addr, 32'h8000_0100);
            end
            nxt();
            smp();
            chk($sformatf("cont%0d_if_resp", i), {31'd0, if_resp_valid}, {31'd0, ~is_ls});
            chk($sformatf("cont%0d_ls_resp", i), {31'd0, ls_resp_valid}, {31'd0, is_ls});
            nxt();
        end
        if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
        nxt();

        // Backpressure: IFU read stalls 5 cycles in REQ while LSU waits
        if_req_valid = 1; if_addr = 32'h8000_0040; if_wen = 0;
        smp();
        chk("bp_if_ready", {31'd0, if_req_ready}, 32'd1);
        nxt();
        if_req_valid = 0; ls_req_valid = 1; ls_wen = 0; ls_addr = 32'h8000_0200;
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = (i == 5);
            smp();
            chk($sformatf("bp%0d_mem_valid", i), {31'd0, mem_req_valid}, 32'd1);
            chk($sformatf("bp%0d_mem_addr", i), mem_addr, 32'h8000_0040);
            chk($sformatf("bp%0d_ls_ready", i), {31'd0, ls_req_ready}, 32'd0);
            nxt();
        end
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_CAFE;
        smp();
        chk("bp_if_resp", {31'd0, if_resp_valid}, 32'd1);
        chk("bp_ls_ready_resp", {31'd0, ls_req_ready}, 32'd0);
        nxt();
        mem_resp_valid = 0;

        // Timeout: LSU read, memory never responds
        smp();
        chk("to_ls_ready", {31'd0, ls_req_ready}, 32'd1);
        nxt();
        ls_req_valid = 0; mem_req_ready = 1;
        nxt();
        mem_req_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            smp();
            chk($sformatf("to_resp%0d_valid", i), {31'd0, ls_resp_valid}, {31'd0, i == 4});
            chk($sformatf("to_resp%0d_err", i), {31'd0, ls_resp_err}, {31'd0, i == 4});
            chk($sformatf("to_resp%0d_if", i), {31'd0, if_resp_valid}, 32'd0);
            if (i == 4) chk("to_rdata", ls_rdata, 32'd0);
            nxt();
        end

        // Tie: response arrives in the timeout cycle
        if_req_valid = 1; if_addr = 32'h8000_0080;
        smp();
        chk("tie_if_ready", {31'd0, if_req_ready}, 32'd1);
        nxt();
        if_req_valid = 0; mem_req_ready = 1;
        nxt();
        mem_req_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            mem_resp_valid = (i == 4);
            mem_rdata = 32'h0000_55AA;
            smp();
            chk($sformatf("tie_resp%0d_valid", i), {31'd0, if_resp_valid}, {31'd0, i == 4});
            chk($sformatf("tie_resp%0d_err", i), {31'd0, if_resp_err}, 32'd0);
            nxt();
        end
        mem_resp_valid = 0;
        smp();
        chk("tie_idle_rdata", if_rdata, 32'd0);

        // Spurious response in IDLE
        nxt();
        mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        smp();
        chk("spur_if_resp", {31'd0, if_resp_valid}, 32'd0);
        chk("spur_ls_resp", {31'd0, ls_resp_valid}, 32'd0);
        nxt();
        mem_resp_valid = 0;

        // Reset in RESP, late response ignored, next tie goes to IFU
        if_req_valid = 1; if_addr = 32'h8000_00C0;
        nxt();
        if_req_valid = 0; mem_req_ready = 1;
        nxt();
        mem_req_ready = 0;
        rst = 1;
        nxt();
        rst = 0; mem_resp_valid = 1; mem_rdata = 32'h0BAD_0BAD;
        smp();
        chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_resp", {31'd0, if_resp_valid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        nxt();
        mem_resp_valid = 0;
        if_req_valid = 1; ls_req_valid = 1;
        smp();
        chk("rst_tie_if_ready", {31'd0, if_req_ready}, 32'd1);
        chk("rst_tie_ls_ready", {31'd0, ls_req_ready}, 32'd0);
        nxt();
        if_req_valid = 0; ls_req_valid = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
# ysyx_24100005_mem_arbiter

Two-requester arbiter and sequencer for the core's single data-memory port. The instruction-fetch unit (IFU) and the load/store unit (LSU) each issue word-wide read/write requests. The arbiter grants one at a time using round-robin, registers the winning request, and drives the memory-side valid/ready handshake. It returns the response, or a timeout error, to the owner only. It sits between the IFU/LSU and the DPI-backed memory model; at most one transaction is outstanding.

## Interface
- `TIMEOUT`, default 255: cycles to wait in RESP before an error response is forced (1..65535).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req_valid` / `ls_req_valid`  in  1  requester has a request.
- `if_req_ready` / `ls_req_ready`  out  1  request accepted this cycle (grant pulse).
- `if_addr` / `ls_addr`  in  32  byte address.
- `if_wen` / `ls_wen`  in  1  1 = write, 0 = read.
- `if_wdata` / `ls_wdata`  in  32  write data.
- `if_wmask` / `ls_wmask`  in  8  byte write mask (low 4 bits used).
- `if_resp_valid` / `ls_resp_valid`  out  1  one-cycle response pulse to the owner.
- `if_rdata` / `ls_rdata`  out  32  read data; valid only with `resp_valid`.
- `if_resp_err` / `ls_resp_err`  out  1  response is a timeout; qualified by `resp_valid`.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_addr`, `mem_wdata`  out  32  registered request fields.
- `mem_wen`  out  1  registered request field.
- `mem_wmask`  out  8  registered request field.
- `mem_resp_valid`  in  1  memory response (read data or write ack).
- `mem_rdata`  in  32  memory read data.

## Operation
- **States.** IDLE, REQ, RESP. Registers: `owner` (0 = IFU, 1 = LSU), `last` (last granted), request latch (addr/wen/wdata/wmask), and a 16-bit timeout counter.
- **IDLE.**
  - If exactly one `*_req_valid` is high, grant it.
  - If both are high, grant the requester that is not `last`.
  - On a grant: pulse that `*_req_ready` (combinational in IDLE), latch its fields, set `owner` and `last`, go to REQ.
  - With no request, stay in IDLE.
- **REQ.** `mem_req_valid` = 1 with the latched fields. When `mem_req_ready` is high, go to RESP and clear the counter. The fields stay stable until the handshake.
- **RESP.**
  - On `mem_resp_valid`: drive the owner's `resp_valid` = 1 and `rdata` = `mem_rdata` with `resp_err` = 0 in the same cycle (combinational route), then go to IDLE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT - 1` without a response, drive the owner's `resp_valid` = 1, `resp_err` = 1, `rdata` = 0, then go to IDLE.
- **Writes.** Same flow; the response is a write ack and `rdata` is don't-care (driven as `mem_rdata`).
- **Non-owner outputs.** `resp_valid`, `resp_err` and `rdata` are 0 for the non-owner at all times.
- **Spurious responses.** `mem_resp_valid` in IDLE or REQ is ignored and produces no response. `mem_req_ready` outside REQ is ignored.
- **Request hold.** Requesters hold `req_valid` until `req_ready`. Requests that arrive during REQ or RESP wait; grant decisions are made only in IDLE.
- **No fixed priority.** Round-robin alternates strictly under continuous contention, so there is no starvation.

## Timing
- **Reset values.** State = IDLE, `owner` = 0, `last` = 1 (the IFU wins the first tie), counter = 0. Request latch = 0. All outputs = 0.
- **Reset mid-transaction.** Returns to IDLE next edge. The in-flight transaction is dropped with no response. A late `mem_resp_valid` afterward is ignored as spurious.
- **Best-case latency.** Grant cycle N (IDLE) → `mem_req_valid` cycle N+1. If `mem_req_ready` is high at N+1 → RESP at N+2. If `mem_resp_valid` is high at N+2 → owner `resp_valid` at N+2. Next grant possible at N+3.
- **Throughput.** At most one transaction per 3 cycles; no overlap.
- **Timeout.** The error response is asserted in the `TIMEOUT`-th RESP cycle. A `mem_resp_valid` arriving in that same cycle takes precedence, giving a normal response with err = 0.
- **Width rules.**
  - The counter is 16 bits and compared against `TIMEOUT - 1`; it never wraps because the state exits first.
  - `mem_wmask` is passed through unmodified.

## Test plan
- **Single read.** Reset, then IFU read addr 0x8000_0000. Memory ready immediately and responds 0x0000_0413 one cycle after acceptance. Expect `if_req_ready` at cycle 0, `mem_req_valid` at 1, `if_resp_valid` with rdata 0x0000_0413 at 2, `ls_resp_valid` = 0 throughout.
- **Contention.** Both valid continuously from reset, LSU writing 0xDEAD_BEEF with mask 0x0F to 0x8000_0100. Expect grant order IFU, LSU, IFU, LSU. Expect `mem_wen` = 1, `mem_wdata` = 0xDEAD_BEEF and `mem_wmask` = 0x0F on LSU turns.
- **Backpressure.** `mem_req_ready` held low for 5 cycles. Expect `mem_req_valid` and `mem_addr` stable for all 6 REQ cycles, and no second grant while `ls_req_valid` is high.
- **Timeout.** `TIMEOUT` = 4, memory never responds. Expect `ls_resp_valid` = 1 and `ls_resp_err` = 1 in the 4th RESP cycle, then IDLE. Check the tie case: a response arriving in the 4th cycle gives err = 0.
- **Spurious response and reset.** A `mem_resp_valid` pulse in IDLE gives no `resp_valid`. Assert `rst` in RESP: expect all outputs 0 next cycle. A late `mem_resp_valid` afterward is ignored, and the next tie grants the IFU.
